// File: rtl/cg_approx_mult_pipe.sv
// Two-stage pipelined unsigned multiplier with per-transaction exact/approximate mode.
// Repeated operand tuples skip the data-register reloads; counters expose how often that happens.
module cg_approx_mult_pipe #(
  parameter int WIDTH       = 8,
  parameter int APPROX_COLS = 3,
  parameter int CNT_W       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  input  logic                 mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   Y,
  output logic                 out_mode,
  output logic [CNT_W-1:0]     op_cnt,
  output logic [CNT_W-1:0]     gated_cnt
);

  localparam int PW = 2 * WIDTH;

  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;
  logic             s1_mode;
  logic             s1_valid;
  logic             s1_repeat;
  logic             last_valid;
  logic             s2_adv;
  logic             accept;
  logic             is_repeat;
  logic [PW-1:0]    product;

  // Columns below APPROX_COLS are XOR-reduced in approximate mode; everything else is summed exactly.
  function automatic logic [PW-1:0] approx_mult(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b,
                                                input logic             m);
    logic [PW-1:0] low;
    logic [PW-1:0] high;
    logic [PW-1:0] term;
    low  = '0;
    high = '0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j < WIDTH; j++) begin
        term = PW'(a[i] & b[j]) << (i + j);
        if (m && ((i + j) < APPROX_COLS)) begin
          low = low ^ term;
        end else begin
          high = high + term;
        end
      end
    end
    return low + high;
  endfunction

  assign s2_adv    = en & (~out_valid | out_ready);
  assign in_ready  = en & (~s1_valid | s2_adv);
  assign accept    = in_valid & in_ready;
  // S1 data registers always hold the most recently accepted tuple.
  assign is_repeat = last_valid & (A == s1_a) & (B == s1_b) & (mode == s1_mode);
  assign product   = approx_mult(s1_a, s1_b, s1_mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_repeat  <= 1'b0;
      last_valid <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_mode    <= 1'b0;
    end else if (en) begin
      if (accept) begin
        s1_valid   <= 1'b1;
        s1_repeat  <= is_repeat;
        last_valid <= 1'b1;
        if (!is_repeat) begin
          s1_a    <= A;
          s1_b    <= B;
          s1_mode <= mode;
        end
      end else if (s2_adv) begin
        s1_valid <= 1'b0;
      end
    end
  end

  // A repeat entry leaves Y untouched: it already holds the identical predecessor result.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      Y         <= '0;
      out_mode  <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid && !s1_repeat) begin
        Y        <= product;
        out_mode <= s1_mode;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_cnt    <= '0;
      gated_cnt <= '0;
    end else if (en && accept) begin
      if (op_cnt != {CNT_W{1'b1}}) begin
        op_cnt <= op_cnt + CNT_W'(1);
      end
      if (is_repeat && (gated_cnt != {CNT_W{1'b1}})) begin
        gated_cnt <= gated_cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_cg_approx_mult_pipe.sv
// Self-checking bench: transaction-level pipeline model plus hand-computed directed vectors.
module tb_cg_approx_mult_pipe;

  localparam int W  = 8;
  localparam int K  = 3;
  localparam int CW = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            en;
  logic            in_valid;
  logic            in_ready;
  logic [W-1:0]    A;
  logic [W-1:0]    B;
  logic            mode;
  logic            out_valid;
  logic            out_ready;
  logic [2*W-1:0]  Y;
  logic            out_mode;
  logic [CW-1:0]   op_cnt;
  logic [CW-1:0]   gated_cnt;

  int total = 0;
  int bad   = 0;

  cg_approx_mult_pipe #(.WIDTH(W), .APPROX_COLS(K), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .mode(mode), .out_valid(out_valid), .out_ready(out_ready),
    .Y(Y), .out_mode(out_mode), .op_cnt(op_cnt), .gated_cnt(gated_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: exact product, then replace each low column's weighted count by its parity.
  function automatic logic [2*W-1:0] ref_y(input int a, input int b, input bit m);
    int cnt [2*W];
    int exact;
    int res;
    exact = a * b;
    if (!m) return exact[2*W-1:0];
    for (int c = 0; c < 2*W; c++) cnt[c] = 0;
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W; j++)
        if (((a >> i) & 1) == 1 && ((b >> j) & 1) == 1) cnt[i+j]++;
    res = exact;
    for (int c = 0; c < K; c++) res = res - cnt[c] * (1 << c) + (cnt[c] % 2) * (1 << c);
    return res[2*W-1:0];
  endfunction

  typedef struct {
    logic [2*W-1:0] y;
    bit             m;
    int             stage;
  } item_t;

  item_t q[$];
  logic [2*W-1:0] m_y = '0;
  bit             m_mode = 1'b0;
  int             m_op = 0;
  int             m_gated = 0;
  bit             m_last_valid = 1'b0;
  logic [2*W:0]   m_last_tuple = '0;
  int             max_cnt = (1 << CW) - 1;

  function automatic bit m_ready();
    return en && (q.size() < 2 || out_ready);
  endfunction

  function automatic bit m_out_valid();
    return q.size() > 0 && q[0].stage == 2;
  endfunction

  // Model: items in flight are either waiting in the first slot or presented at the output.
  always @(posedge clk) begin
    bit    acc;
    bit    rep;
    item_t it;
    if (rst) begin
      q.delete();
      m_y = '0;
      m_mode = 1'b0;
      m_op = 0;
      m_gated = 0;
      m_last_valid = 1'b0;
    end else if (en) begin
      acc = in_valid && m_ready();
      if (m_out_valid() && out_ready) it = q.pop_front();
      if (q.size() > 0 && q[0].stage == 1) begin
        it = q[0];
        it.stage = 2;
        q[0] = it;
        m_y = it.y;
        m_mode = it.m;
      end
      if (acc) begin
        rep = m_last_valid && (m_last_tuple == {A, B, mode});
        if (m_op < max_cnt) m_op++;
        if (rep && m_gated < max_cnt) m_gated++;
        m_last_valid = 1'b1;
        m_last_tuple = {A, B, mode};
        it.y = ref_y(int'(A), int'(B), mode);
        it.m = mode;
        it.stage = 1;
        q.push_back(it);
      end
    end
  end

  always @(negedge clk) begin
    check("out_valid", 32'(out_valid), 32'(m_out_valid()));
    check("Y", 32'(Y), 32'(m_y));
    check("out_mode", 32'(out_mode), 32'(m_mode));
    check("in_ready", 32'(in_ready), 32'(m_ready()));
    check("op_cnt", 32'(op_cnt), 32'(m_op));
    check("gated_cnt", 32'(gated_cnt), 32'(m_gated));
  end

  task automatic single(input int a, input int b, input bit m, input int exp, input string name);
    A = a[W-1:0];
    B = b[W-1:0];
    mode = m;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check({name, "_early"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check({name, "_valid"}, 32'(out_valid), 32'd1);
    check(name, 32'(Y), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic new_tuple(input bit rmode);
    A = W'($urandom);
    B = W'($urandom);
    mode = rmode ? 1'($urandom_range(0, 1)) : 1'b0;
  endtask

  // Streams n transactions; out_ready is low in [st_lo,st_hi], en is low in [en_lo,en_hi].
  task automatic stream(input int n, input int st_lo, input int st_hi,
                        input int en_lo, input int en_hi, input bit rmode);
    int idx = 0;
    int cyc = 0;
    int op0 = 0;
    bit acc;
    new_tuple(rmode);
    while (idx < n && cyc < 200) begin
      out_ready = !(cyc >= st_lo && cyc <= st_hi);
      en = !(cyc >= en_lo && cyc <= en_hi);
      in_valid = 1'b1;
      #1;
      acc = in_ready;
      if (st_hi < 0 && en_hi < 0) check("ir_stream", 32'(in_ready), 32'd1);
      if (cyc == st_hi && st_hi >= st_lo + 2) check("ir_stall", 32'(in_ready), 32'd0);
      if (cyc == en_lo) op0 = int'(op_cnt);
      if (cyc >= en_lo && cyc <= en_hi) begin
        check("ir_en_off", 32'(in_ready), 32'd0);
        check("op_frozen", 32'(op_cnt), 32'(op0));
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        new_tuple(rmode);
      end
      cyc++;
    end
    check("stream_done", 32'(idx), 32'(n));
    if (st_hi < 0 && en_hi < 0) check("stream_cycles", 32'(cyc), 32'(n));
    in_valid = 1'b0;
    en = 1'b1;
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b1;
    in_valid = 1'b0;
    A = '0;
    B = '0;
    mode = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_Y", 32'(Y), 32'd0);
    check("rst_op_cnt", 32'(op_cnt), 32'd0);
    @(posedge clk);
    #1;

    single(15, 15, 1'b0, 225, "exact_15x15");
    single(15, 15, 1'b1, 213, "approx_15x15");
    single(3, 3, 1'b1, 5, "approx_3x3");
    single(5, 3, 1'b1, 15, "approx_5x3");

    stream(20, 1000, -1, 1000, -1, 1'b0);
    stream(10, 3, 7, 1000, -1, 1'b1);
    stream(8, 1000, -1, 3, 6, 1'b1);
    check("op_cnt_saturated", 32'(op_cnt), 32'd31);

    // Fill both stages (second entry is a repeat), then reset mid-flight.
    out_ready = 1'b0;
    A = 8'd11;
    B = 8'd13;
    mode = 1'b1;
    in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("flush_out_valid", 32'(out_valid), 32'd0);
    check("flush_Y", 32'(Y), 32'd0);
    check("flush_op_cnt", 32'(op_cnt), 32'd0);
    check("flush_gated_cnt", 32'(gated_cnt), 32'd0);
    @(posedge clk);
    #1 in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    check("post_rst_op", 32'(op_cnt), 32'd1);
    check("post_rst_not_repeat", 32'(gated_cnt), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;

    // Three identical approximate requests then the same operands in exact mode.
    A = 8'd7;
    B = 8'd9;
    mode = 1'b1;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1 mode = 1'b0;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("gate_op_cnt", 32'(op_cnt), 32'd4);
    check("gate_gated_cnt", 32'(gated_cnt), 32'd2);
    check("gate_Y", 32'(Y), 32'd63);
    check("gate_out_mode", 32'(out_mode), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
